// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: timeout retries, lock qualification and a registered system reset.
// Optional build macro PLL_GLITCH_FILTER_EN debounces lock dips while in RUN.
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 8,
  parameter int GLITCH_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lock_in,
  input  logic             relock_req,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             locked,
  output logic             fail,
  output logic [CNT_W-1:0] loss_count,
  output logic [2:0]       state_o
);
  localparam int T_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int T_MAX = (T_AB > STABLE_CYCLES) ? T_AB : STABLE_CYCLES;
  localparam int TW    = $clog2(T_MAX + 1);
  localparam int RW    = $clog2(MAX_RETRIES + 1);
  localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STB_LAST  = TW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [TW-1:0]    timer_r, timer_s;
  logic [RW-1:0]    retries_r, retries_s, retries_inc_s;
  logic             lock_meta_r, lock_sync_r;
  logic             loss_take_s, loss_s;
  logic             pll_rst_r, sys_rst_r, locked_r, fail_r;
  logic             pll_rst_s, sys_rst_s, locked_s, fail_s;
  logic [CNT_W-1:0] loss_count_r, loss_count_s;
  logic [2:0]       state_o_r;

  assign retries_inc_s = retries_r + RW'(1);

`ifdef PLL_GLITCH_FILTER_EN
  localparam int GW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
  localparam logic [GW-1:0] GLITCH_LAST = GW'(GLITCH_CYCLES - 1);
  logic [GW-1:0] glitch_r, glitch_s;

  // Consecutive low lock samples while in RUN; any high sample or leaving RUN restarts it.
  always_comb begin
    if ((state_r == ST_RUN) && !relock_req && !lock_sync_r && (glitch_r != GLITCH_LAST)) begin
      glitch_s = glitch_r + GW'(1);
    end else begin
      glitch_s = '0;
    end
  end

  // Glitch filter counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      glitch_r <= '0;
    end else begin
      glitch_r <= glitch_s;
    end
  end

  assign loss_take_s = !lock_sync_r && (glitch_r == GLITCH_LAST);
`else
  assign loss_take_s = !lock_sync_r;
  if (GLITCH_CYCLES < 1) begin : g_glitch_cfg
    $error("GLITCH_CYCLES must be at least 1");
  end
`endif

  // Lock synchronizer, FSM state, shared phase timer and retry counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_meta_r <= 1'b0;
      lock_sync_r <= 1'b0;
      state_r     <= ST_RST;
      timer_r     <= '0;
      retries_r   <= '0;
    end else begin
      lock_meta_r <= lock_in;
      lock_sync_r <= lock_meta_r;
      state_r     <= state_s;
      timer_r     <= timer_s;
      retries_r   <= retries_s;
    end
  end

  // Next-state logic; relock_req outranks every lock or timeout event.
  always_comb begin
    state_s   = state_r;
    timer_s   = timer_r;
    retries_s = retries_r;
    loss_s    = 1'b0;
    if (relock_req) begin
      state_s   = ST_RST;
      timer_s   = '0;
      retries_s = '0;
    end else begin
      case (state_r)
        ST_RST: begin
          if (timer_r == RST_LAST) begin
            state_s = ST_WAIT;
            timer_s = '0;
          end else begin
            timer_s = timer_r + TW'(1);
          end
        end
        ST_WAIT: begin
          if (lock_sync_r) begin
            state_s = ST_STABLE;
            timer_s = '0;
          end else if (timer_r == WAIT_LAST) begin
            timer_s   = '0;
            retries_s = retries_inc_s;
            if (retries_inc_s == RETRY_MAX) begin
              state_s = ST_FAIL;
            end else begin
              state_s = ST_RST;
            end
          end else begin
            timer_s = timer_r + TW'(1);
          end
        end
        ST_STABLE: begin
          if (!lock_sync_r) begin
            state_s = ST_WAIT;
            timer_s = '0;
          end else if (timer_r == STB_LAST) begin
            state_s   = ST_RUN;
            timer_s   = '0;
            retries_s = '0;
          end else begin
            timer_s = timer_r + TW'(1);
          end
        end
        ST_RUN: begin
          if (loss_take_s) begin
            state_s = ST_RST;
            timer_s = '0;
            loss_s  = 1'b1;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_FAIL: begin
          state_s = ST_FAIL;
        end
        default: begin
          state_s   = ST_RST;
          timer_s   = '0;
          retries_s = '0;
        end
      endcase
    end
  end

  // Output decode from the next state so the registered outputs track state_r exactly.
  always_comb begin
    pll_rst_s = 1'b1;
    sys_rst_s = 1'b1;
    locked_s  = 1'b0;
    fail_s    = 1'b0;
    case (state_s)
      ST_RST:    pll_rst_s = 1'b1;
      ST_WAIT:   pll_rst_s = 1'b0;
      ST_STABLE: pll_rst_s = 1'b0;
      ST_RUN: begin
        pll_rst_s = 1'b0;
        sys_rst_s = 1'b0;
        locked_s  = 1'b1;
      end
      ST_FAIL:   fail_s = 1'b1;
      default:   pll_rst_s = 1'b1;
    endcase
    if (loss_s && (loss_count_r != {CNT_W{1'b1}})) begin
      loss_count_s = loss_count_r + CNT_W'(1);
    end else begin
      loss_count_s = loss_count_r;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pll_rst_r    <= 1'b1;
      sys_rst_r    <= 1'b1;
      locked_r     <= 1'b0;
      fail_r       <= 1'b0;
      loss_count_r <= '0;
      state_o_r    <= 3'd0;
    end else begin
      pll_rst_r    <= pll_rst_s;
      sys_rst_r    <= sys_rst_s;
      locked_r     <= locked_s;
      fail_r       <= fail_s;
      loss_count_r <= loss_count_s;
      state_o_r    <= state_s;
    end
  end

  assign pll_rst    = pll_rst_r;
  assign sys_rst    = sys_rst_r;
  assign locked     = locked_r;
  assign fail       = fail_r;
  assign loss_count = loss_count_r;
  assign state_o    = state_o_r;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Randomized + directed bench for pll_lock_supervisor with a cycle-level behavioural model.
module tb_pll_lock_supervisor;
  localparam int RSTC = 4;
  localparam int TMO  = 32;
  localparam int STB  = 8;
  localparam int MAXR = 2;
`ifdef PLL_GLITCH_FILTER_EN
  localparam int GL = 3;
`else
  localparam int GL = 1;
`endif

  logic       clk, reset, lock_in, relock_req;
  logic       pll_rst, sys_rst, locked, fail;
  logic [3:0] loss_count;
  logic [2:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  pll_lock_supervisor #(
    .RST_CYCLES(RSTC), .LOCK_TIMEOUT(TMO), .STABLE_CYCLES(STB),
    .MAX_RETRIES(MAXR), .CNT_W(4), .GLITCH_CYCLES(3)
  ) dut (
    .clk(clk), .reset(reset), .lock_in(lock_in), .relock_req(relock_req),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .locked(locked), .fail(fail),
    .loss_count(loss_count), .state_o(state_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0..4 = RST/WAIT/STABLE/RUN/FAIL, age = cycles spent in phase.
  int m_phase, m_age, m_tries, m_low, m_losses;
  bit m_meta, m_sync, m_valid;

  task automatic model_step();
    bit ls;
    if (reset) begin
      m_phase = 0; m_age = 0; m_tries = 0; m_low = 0; m_losses = 0;
      m_meta = 1'b0; m_sync = 1'b0; m_valid = 1'b1;
    end else begin
      ls = m_sync;
      m_sync = m_meta;
      m_meta = lock_in;
      if (relock_req) begin
        m_phase = 0; m_age = 0; m_tries = 0; m_low = 0;
      end else begin
        case (m_phase)
          0: begin
            m_age++;
            if (m_age == RSTC) begin m_phase = 1; m_age = 0; end
          end
          1: begin
            if (ls) begin
              m_phase = 2; m_age = 0;
            end else begin
              m_age++;
              if (m_age == TMO) begin
                m_tries++; m_age = 0;
                m_phase = (m_tries == MAXR) ? 4 : 0;
              end
            end
          end
          2: begin
            if (!ls) begin
              m_phase = 1; m_age = 0;
            end else begin
              m_age++;
              if (m_age == STB) begin m_phase = 3; m_age = 0; m_tries = 0; end
            end
          end
          3: begin
            if (ls) begin
              m_low = 0;
            end else begin
              m_low++;
              if (m_low == GL) begin
                m_phase = 0; m_age = 0; m_low = 0;
                if (m_losses < 15) m_losses++;
              end
            end
          end
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    m_valid = 1'b0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("pll_rst", int'(pll_rst), int'(m_phase == 0 || m_phase == 4));
        check("sys_rst", int'(sys_rst), int'(m_phase != 3));
        check("locked", int'(locked), int'(m_phase == 3));
        check("fail", int'(fail), int'(m_phase == 4));
        check("state_o", int'(state_o), m_phase);
        check("loss_count", int'(loss_count), m_losses);
      end
    end
  end

  task automatic wait_state(input int st, input int budget);
    int n;
    n = 0;
    while ((int'(state_o) != st) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check("wait_state", int'(state_o), st);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pll_rst"}, int'(pll_rst), 1);
    check({tag, "_sys_rst"}, int'(sys_rst), 1);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_fail"}, int'(fail), 0);
    check({tag, "_loss"}, int'(loss_count), 0);
    check({tag, "_state"}, int'(state_o), 0);
  endtask

  initial begin
    int first_wait, first_run, first_fail, run_locked, hold;
    reset = 1'b1; lock_in = 1'b0; relock_req = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");

    // Clean lock straight out of reset.
    reset = 1'b0; lock_in = 1'b1;
    first_wait = -1; first_run = -1; run_locked = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (first_wait < 0 && state_o == 3'd1) first_wait = i;
      if (first_run < 0 && !sys_rst) begin first_run = i; run_locked = int'(locked); end
    end
    check("clean_rst_len", first_wait, 4);
    check("clean_run_at", first_run, 13);
    check("clean_locked_with_sysrst", run_locked, 1);
    check("clean_state", int'(state_o), 3);

`ifdef PLL_GLITCH_FILTER_EN
    lock_in = 1'b0;
    repeat (2) @(negedge clk);
    lock_in = 1'b1;
    repeat (8) @(negedge clk);
    check("glitch_state", int'(state_o), 3);
    check("glitch_loss", int'(loss_count), 0);
    check("glitch_sysrst", int'(sys_rst), 0);
`endif

    // relock_req lands on the same edge a loss would be taken.
    lock_in = 1'b0;
    repeat (GL + 1) @(negedge clk);
    relock_req = 1'b1;
    @(negedge clk);
    relock_req = 1'b0;
    check("simul_state", int'(state_o), 0);
    check("simul_loss", int'(loss_count), 0);
    check("simul_sysrst", int'(sys_rst), 1);

    // Unstable lock: 5 high, 1 low, then high.
    wait_state(1, 20);
    lock_in = 1'b1;
    repeat (5) @(negedge clk);
    lock_in = 1'b0;
    @(negedge clk);
    lock_in = 1'b1;
    first_run = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (first_run < 0 && !sys_rst) first_run = i;
    end
    check("unstable_run_at", first_run, 11);
    check("unstable_loss", int'(loss_count), 0);

    // Repeated losses in RUN saturate the counter.
    for (int k = 0; k < 20; k++) begin
      lock_in = 1'b0;
      repeat (GL) @(negedge clk);
      lock_in = 1'b1;
      wait_state(0, 10);
      if (k == 0) begin
        check("loss_first_count", int'(loss_count), 1);
        check("loss_first_sysrst", int'(sys_rst), 1);
      end
      wait_state(3, 60);
    end
    check("loss_saturated", int'(loss_count), 15);

    // Never locks: two attempts then FAIL.
    lock_in = 1'b0; relock_req = 1'b1;
    first_fail = -1;
    for (int i = 1; i <= 90; i++) begin
      @(negedge clk);
      relock_req = 1'b0;
      if (first_fail < 0 && fail) first_fail = i;
    end
    check("nolock_fail_at", first_fail, 73);
    check("nolock_state", int'(state_o), 4);
    check("nolock_pll_rst", int'(pll_rst), 1);
    relock_req = 1'b1;
    @(negedge clk);
    relock_req = 1'b0;
    check("relock_fail", int'(fail), 0);
    check("relock_state", int'(state_o), 0);

    // Reset asserted mid-STABLE.
    lock_in = 1'b1;
    wait_state(2, 30);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midreset");
    reset = 1'b0;

    // Randomized phase.
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        lock_in = ($urandom_range(0, 3) != 0);
        hold = lock_in ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 6));
        if ($urandom_range(0, 9) == 0) hold = int'($urandom_range(30, 120));
      end
      hold--;
      relock_req = ($urandom_range(0, 99) == 0);
      reset = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    reset = 1'b0; relock_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
